// File: rtl/arbitro_ram_pkg.sv
// Shared types and constants for the audio RAM read arbiter.
// Pure declarations: no latency or flow control of its own.
`timescale 1ns/1ps
package arbitro_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] REQ_MUSICA = 2'd0;
  localparam logic [1:0] REQ_EFECTO = 2'd1;
  localparam logic [1:0] REQ_NOTAS  = 2'd2;

  localparam int READ_WAIT_DEF = 6;

  // Round-robin successor over the three requesters: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= REQ_NOTAS) ? REQ_MUSICA : i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_grant3.sv
// Picks the first active request at or after ptr (0->1->2->0); combinational, zero latency.
// No backpressure: vld simply reports whether any request is present.
`timescale 1ns/1ps
module rr_grant3
  import arbitro_ram_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       vld
);

  logic [1:0] cand;
  logic       hit;

  always_comb begin
    gnt  = REQ_MUSICA;
    vld  = 1'b0;
    hit  = 1'b0;
    cand = (ptr > REQ_NOTAS) ? REQ_MUSICA : ptr;
    for (int i = 0; i < 3; i++) begin
      hit = (cand == REQ_MUSICA) ? req[0] :
            (cand == REQ_EFECTO) ? req[1] : req[2];
      if (!vld && hit) begin
        gnt = cand;
        vld = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

endmodule

// File: rtl/arbitro_ram_audio.sv
// Round-robin arbiter running one async RAM read per grant; ack READ_WAIT+2 cycles after grant.
// Requesters hold req until ack; pausa blocks new grants only in IDLE, in-flight reads finish.
`timescale 1ns/1ps
module arbitro_ram_audio
  import arbitro_ram_pkg::*;
#(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 16,
  parameter int READ_WAIT = READ_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pausa,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              ack0,
  output logic              ack1,
  output logic              ack2,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  input  logic [DATA_W-1:0] ram_dq_i
);

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [1:0]        ptr;
  logic [1:0]        gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_vld;
  logic              take;
  logic              rd_active;
  logic [ADDR_W-1:0] addr_sel;

  rr_grant3 u_rr (
    .req ({req2, req1, req0}),
    .ptr (ptr),
    .gnt (gnt_idx),
    .vld (gnt_vld)
  );

  assign take = (state == IDLE) && !pausa && gnt_vld;

  always_comb begin
    addr_sel = addr0;
    case (gnt_idx)
      REQ_EFECTO: addr_sel = addr1;
      REQ_NOTAS:  addr_sel = addr2;
      default:    addr_sel = addr0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SETUP;
      SETUP:   state_nxt = WAIT;
      WAIT:    if (cnt == WAIT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins decode straight from state so an async reset releases CE/OE immediately.
  always_comb begin
    rd_active = (state == SETUP) || (state == WAIT);
    ram_ce_n  = !rd_active;
    ram_oe_n  = !rd_active;
    ack0      = (state == DONE) && (gnt == REQ_MUSICA);
    ack1      = (state == DONE) && (gnt == REQ_EFECTO);
    ack2      = (state == DONE) && (gnt == REQ_NOTAS);
  end

  assign ram_we_n = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ptr      <= REQ_MUSICA;
      gnt      <= REQ_MUSICA;
      ram_addr <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            gnt      <= gnt_idx;
            ram_addr <= addr_sel;
          end
        end
        SETUP: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == WAIT_LAST) rdata <= ram_dq_i;
        end
        DONE: ptr <= next_idx(gnt);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_ram_audio.sv
// Scoreboard bench for arbitro_ram_audio with a behavioural 70 ns async RAM.
`timescale 1ns/1ps
module tb_arbitro_ram_audio;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int RW     = 6;
  localparam int PER    = RW + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pausa = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic              ack0, ack1, ack2;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ce_n, ram_oe_n, ram_we_n;
  logic [DATA_W-1:0] ram_dq_i;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  wire  [2:0]  acks = {ack2, ack1, ack0};

  arbitro_ram_audio #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .pausa(pausa),
    .req0(req0), .req1(req1), .req2(req2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .ack0(ack0), .ack1(ack1), .ack2(ack2),
    .rdata(rdata), .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_dq_i(ram_dq_i)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] ram_fn(input logic [ADDR_W-1:0] a);
    if (a == 26'h000123) return 16'hBEEF;
    return {a[7:0] ^ 8'hA5, ~a[7:0]};
  endfunction

  // Async RAM: output undefined after any pin change, valid 70 ns later while selected.
  always begin
    @(ram_addr or ram_ce_n or ram_oe_n);
    ram_dq_i = 'x;
    #70;
    if (!ram_ce_n && !ram_oe_n) ram_dq_i = ram_fn(ram_addr);
  end

  // Scoreboard: every ack is matched in order against {index, data}.
  always @(negedge clk) begin
    logic [1:0]  idx;
    logic [17:0] e;
    total++;
    if (ram_we_n !== 1'b1) begin
      bad++;
      $display("FAIL we_n: got %b want 1", ram_we_n);
    end
    if (acks != 3'b000) begin
      case (acks)
        3'b001:  idx = 2'd0;
        3'b010:  idx = 2'd1;
        3'b100:  idx = 2'd2;
        default: idx = 2'd3;
      endcase
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: acks=%b rdata=%h with empty scoreboard", acks, rdata);
      end else begin
        e = exp_q.pop_front();
        if ({idx, rdata} !== e) begin
          bad++;
          $display("FAIL sb_ack: got idx=%0d data=%h want idx=%0d data=%h", idx, rdata, e[17:16], e[15:0]);
        end
      end
    end
  end

  task automatic push(input logic [1:0] idx, input logic [ADDR_W-1:0] a);
    exp_q.push_back({idx, ram_fn(a)});
  endtask

  task automatic wait_ack(input int which, input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (acks[which]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin
      bad++; $display("FAIL reset_pins: got %b want 111", {ram_ce_n, ram_oe_n, ram_we_n});
    end
    total++;
    if (ram_addr !== '0 || rdata !== '0) begin
      bad++; $display("FAIL reset_regs: got addr=%h rdata=%h want 0 0", ram_addr, rdata);
    end
    total++;
    if (acks !== 3'b000) begin
      bad++; $display("FAIL reset_acks: got %b want 000", acks);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ram_ce_n !== 1'b1) begin
      bad++; $display("FAIL idle_ce: got %b want 1", ram_ce_n);
    end
  endtask

  task automatic test_single();
    int lowbad = 0;
    @(negedge clk);
    req1 = 1'b1; addr1 = 26'h000123;
    push(2'd1, 26'h000123);
    for (int j = 0; j <= RW; j++) begin
      @(negedge clk);
      if (ram_ce_n !== 1'b0 || ram_oe_n !== 1'b0 || ram_addr !== 26'h000123 || acks !== 3'b000) lowbad++;
    end
    total++;
    if (lowbad != 0) begin
      bad++; $display("FAIL single_ce_window: got %0d bad cycles want 0", lowbad);
    end
    @(negedge clk);
    total++;
    if (ack1 !== 1'b1 || rdata !== 16'hBEEF || ram_ce_n !== 1'b1) begin
      bad++; $display("FAIL single_ack: got ack1=%b rdata=%h ce_n=%b want 1 beef 1", ack1, rdata, ram_ce_n);
    end
    req1 = 1'b0;
    @(negedge clk);
    total++;
    if (ack1 !== 1'b0 || ram_ce_n !== 1'b1) begin
      bad++; $display("FAIL single_after: got ack1=%b ce_n=%b want 0 1", ack1, ram_ce_n);
    end
  endtask

  task automatic test_round_robin();
    int nack = 0, last = -1, hi_run = 0;
    bit started = 0;
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 26'h10;
    req1 = 1'b1; addr1 = 26'h20;
    req2 = 1'b1; addr2 = 26'h30;
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 26'h10); push(2'd1, 26'h20); push(2'd2, 26'h30);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100 && nack < 6; c++) begin
      @(negedge clk);
      if (acks != 3'b000) begin
        if (last >= 0) begin
          total++;
          if (c - last != PER) begin
            bad++; $display("FAIL rr_spacing: got %0d want %0d", c - last, PER);
          end
        end
        last = c; nack++; started = 1;
        if (nack == 6) {req0, req1, req2} = 3'b000;
      end
      if (ram_ce_n) hi_run++;
      else begin
        if (started && hi_run > 0) begin
          total++;
          if (hi_run != 2) begin
            bad++; $display("FAIL rr_ce_gap: got %0d want 2", hi_run);
          end
        end
        hi_run = 0;
      end
    end
    total++;
    if (nack != 6) begin
      bad++; $display("FAIL rr_count: got %0d acks want 6", nack);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop();
    int n, lows = 0;
    pulse_reset();
    @(negedge clk);
    req0 = 1'b1; addr0 = 26'h40;
    req1 = 1'b1; addr1 = 26'h50;
    push(2'd0, 26'h40); push(2'd1, 26'h50);
    repeat (4) @(negedge clk);
    req0 = 1'b0;
    wait_ack(0, 20, n);
    total++;
    if (n != 4) begin
      bad++; $display("FAIL drop_ack0: got %0d want 4", n);
    end
    repeat (2) @(negedge clk);
    total++;
    if (ram_addr !== 26'h50 || ram_ce_n !== 1'b0) begin
      bad++; $display("FAIL drop_next_grant: got addr=%h ce_n=%b want 50 0", ram_addr, ram_ce_n);
    end
    wait_ack(1, 20, n);
    total++;
    if (n != RW + 1) begin
      bad++; $display("FAIL drop_ack1: got %0d want %0d", n, RW + 1);
    end
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; addr0 = 26'h44;
    push(2'd0, 26'h44);
    repeat (3) @(negedge clk);
    req0 = 1'b0;
    wait_ack(0, 20, n);
    total++;
    if (n != 5) begin
      bad++; $display("FAIL drop_alone: got %0d want 5", n);
    end
    repeat (10) begin
      @(negedge clk);
      if (!ram_ce_n) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL drop_idle_hold: got %0d ce-low cycles want 0", lows);
    end
  endtask

  task automatic test_reset_mid();
    int n, stray = 0;
    @(negedge clk);
    req2 = 1'b1; addr2 = 26'h60;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 26'h70;
    #1;
    total++;
    if (ram_ce_n !== 1'b1 || ram_oe_n !== 1'b1) begin
      bad++; $display("FAIL rstmid_pins: got ce_n=%b oe_n=%b want 1 1", ram_ce_n, ram_oe_n);
    end
    repeat (2) begin
      @(negedge clk);
      if (acks !== 3'b000) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL rstmid_noack: got %0d ack cycles want 0", stray);
    end
    rst_n = 1'b1;
    push(2'd0, 26'h70); push(2'd2, 26'h60);
    wait_ack(0, 20, n);
    total++;
    if (n != RW + 2) begin
      bad++; $display("FAIL rstmid_first: got %0d want %0d", n, RW + 2);
    end
    req0 = 1'b0;
    wait_ack(2, 20, n);
    total++;
    if (n != PER) begin
      bad++; $display("FAIL rstmid_second: got %0d want %0d", n, PER);
    end
    req2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pausa();
    int n, lows = 0;
    @(negedge clk);
    pausa = 1'b1;
    req2 = 1'b1; addr2 = 26'h80;
    repeat (20) begin
      @(negedge clk);
      if (!ram_ce_n || !ram_oe_n) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL pausa_hold: got %0d ce-low cycles want 0", lows);
    end
    pausa = 1'b0;
    push(2'd2, 26'h80);
    wait_ack(2, 20, n);
    total++;
    if (n != RW + 2) begin
      bad++; $display("FAIL pausa_release: got %0d want %0d", n, RW + 2);
    end
    req2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pausa_setup();
    int n, lows = 0;
    @(negedge clk);
    req0 = 1'b1; addr0 = 26'h90;
    req1 = 1'b1; addr1 = 26'hA0;
    push(2'd0, 26'h90);
    @(negedge clk);
    total++;
    if (ram_ce_n !== 1'b0 || ram_addr !== 26'h90) begin
      bad++; $display("FAIL ps_setup: got ce_n=%b addr=%h want 0 90", ram_ce_n, ram_addr);
    end
    pausa = 1'b1;
    wait_ack(0, 20, n);
    total++;
    if (n != RW + 1) begin
      bad++; $display("FAIL ps_inflight: got %0d want %0d", n, RW + 1);
    end
    repeat (20) begin
      @(negedge clk);
      if (!ram_ce_n) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL ps_blocked: got %0d ce-low cycles want 0", lows);
    end
    pausa = 1'b0;
    push(2'd1, 26'hA0);
    wait_ack(1, 20, n);
    total++;
    if (n != RW + 2) begin
      bad++; $display("FAIL ps_resume: got %0d want %0d", n, RW + 2);
    end
    {req0, req1, req2} = 3'b000;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_pausa();
    test_pausa_setup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200 us");
    $fatal(1, "watchdog");
  end

endmodule
